microseq: RTL and testbench



---
 rtl/microseq.sv | 144 ++++++++++++++
 tb/tb_microseq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microseq.sv
// ---------------------------------------------------------------------------
// microseq -- writable microcode sequencer for the NibblER control path.
//
// Each opcode owns 2^STEPW consecutive microwords at {opcode, step}. The
// sequencer walks them one step per enabled clock. An instruction ends early
// when the current word has its `last` bit set, or it wraps after MAXSTEP.
// A word can be made conditional on one flag (optionally inverted). When the
// condition is false, FALLBACK_CTRL is driven instead of the word's control
// field.
//
// Microword layout (MSB first):
//   {last, cond_en, cond_inv, cond_idx[FIDXW-1:0], ctrl[CTRLW-1:0]}
//
// Ports:
//   clock      in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   en         in   advance one micro-step this cycle
//   opcode     in   current opcode (held by fetch logic across an instruction)
//   flags      in   registered ALU flags, flags[0]=C, flags[1]=Z
//   wr_en      in   microcode write strobe
//   wr_addr    in   write address {opcode, step}
//   wr_data    in   microword to store
//   ctrl       out  current control word (zero while in reset)
//   step       out  current micro-step
//   fetch      out  high when step == 0
//   cond_fail  out  current word is conditional and its condition is false
//   wr_err     out  sticky: a word with cond_idx >= NFLAGS was written
// ---------------------------------------------------------------------------
module microseq #(
    parameter int                OPW           = 4,
    parameter int                STEPW         = 2,
    parameter int                NFLAGS        = 2,
    parameter int                CTRLW         = 13,
    parameter logic [CTRLW-1:0]  FALLBACK_CTRL = 13'h1000,
    localparam int               FIDXW         = (NFLAGS > 1) ? $clog2(NFLAGS) : 1,
    localparam int               MW            = CTRLW + FIDXW + 3,
    localparam int               AW            = OPW + STEPW
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    input  logic [OPW-1:0]    opcode,
    input  logic [NFLAGS-1:0] flags,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [MW-1:0]     wr_data,
    output logic [CTRLW-1:0]  ctrl,
    output logic [STEPW-1:0]  step,
    output logic              fetch,
    output logic              cond_fail,
    output logic              wr_err
);

    // Microcode store. No reset: contents are only meaningful once written.
    logic [MW-1:0]     store_mem [2**AW];

    logic [STEPW-1:0]  step_reg;
    logic [STEPW-1:0]  step_next;
    logic              wr_err_reg;

    // Current microword and its fields.
    logic [MW-1:0]     word;
    logic              word_last;
    logic              word_cond_en;
    logic              word_cond_inv;
    logic [FIDXW-1:0]  word_cond_idx;
    logic [CTRLW-1:0]  word_ctrl;

    logic [FIDXW-1:0]  wr_cond_idx;
    logic [NFLAGS-1:0] flag_hit;
    logic [NFLAGS-1:0] wr_idx_hit;
    logic              flag_sel;
    logic              cond_true;
    logic              cond_fail_word;

    // Combinational read: a write to the address being read this cycle only
    // becomes visible after the clock edge, so the old word is seen now.
    assign word          = store_mem[{opcode, step_reg}];
    assign word_last     = word[MW-1];
    assign word_cond_en  = word[MW-2];
    assign word_cond_inv = word[MW-3];
    assign word_cond_idx = word[CTRLW +: FIDXW];
    assign word_ctrl     = word[CTRLW-1:0];

    assign wr_cond_idx   = wr_data[CTRLW +: FIDXW];

    // One-hot flag select. Indices with no matching flag select nothing,
    // so an out-of-range cond_idx reads as a flag value of 0.
    generate
        for (genvar gi = 0; gi < NFLAGS; gi++) begin : g_flag
            assign flag_hit[gi]   = flags[gi] & (word_cond_idx == FIDXW'(gi));
            assign wr_idx_hit[gi] = (wr_cond_idx == FIDXW'(gi));
        end
    endgenerate

    assign flag_sel       = |flag_hit;
    assign cond_true      = flag_sel ^ word_cond_inv;
    assign cond_fail_word = word_cond_en & ~cond_true;

    // Outputs are forced quiet for as long as reset is held, independent of
    // whatever the store happens to contain.
    always_comb begin
        ctrl      = '0;
        cond_fail = 1'b0;
        if (reset_n) begin
            cond_fail = cond_fail_word;
            ctrl      = cond_fail_word ? FALLBACK_CTRL : word_ctrl;
        end
    end

    // Instruction completes on `last` or after the final step slot.
    always_comb begin
        step_next = step_reg + STEPW'(1);
        if (word_last || (step_reg == {STEPW{1'b1}})) begin
            step_next = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_reg   <= '0;
            wr_err_reg <= 1'b0;
        end else begin
            if (en) begin
                step_reg <= step_next;
            end
            if (wr_en && !(|wr_idx_hit)) begin
                wr_err_reg <= 1'b1;
            end
        end
    end

    // The store keeps accepting writes regardless of reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            store_mem[wr_addr] <= wr_data;
        end
    end

    assign step   = step_reg;
    assign fetch  = (step_reg == '0);
    assign wr_err = wr_err_reg;

endmodule

// File: tb/tb_microseq.sv
// ---------------------------------------------------------------------------
// tb_microseq -- self-checking bench for microseq.
//
// The DUT is built with three flags so that a 2-bit cond_idx can name a
// non-existent flag (index 3), which exercises wr_err and the flag=0 rule.
// A driver applies one set of inputs per cycle and pushes the expected
// outputs, computed from a behavioural model of the store and step counter,
// into a queue. A monitor pops and compares on each falling edge.
// ---------------------------------------------------------------------------
module tb_microseq;

    localparam int NFL     = 3;
    localparam int MAXSTEP = 3;

    logic        clock;
    logic        reset_n;
    logic        en;
    logic [3:0]  opcode;
    logic [2:0]  flags;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [17:0] wr_data;
    logic [12:0] ctrl;
    logic [1:0]  step;
    logic        fetch;
    logic        cond_fail;
    logic        wr_err;

    microseq #(
        .OPW(4), .STEPW(2), .NFLAGS(NFL), .CTRLW(13), .FALLBACK_CTRL(13'h1000)
    ) dut (
        .clock(clock), .reset_n(reset_n), .en(en), .opcode(opcode),
        .flags(flags), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ctrl(ctrl), .step(step), .fetch(fetch), .cond_fail(cond_fail),
        .wr_err(wr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        chk;
        logic [12:0] ctrl;
        logic        cf;
        logic [1:0]  step;
        logic        fetch;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Behavioural model: store as per-field arrays, step as an integer.
    bit          m_valid [64];
    bit          m_last  [64];
    bit          m_cen   [64];
    bit          m_inv   [64];
    int          m_idx   [64];
    logic [12:0] m_ctrl  [64];
    int          m_step;
    bit          m_err;

    function automatic logic [17:0] pack(input logic last, input logic cen,
                                         input logic inv, input logic [1:0] idx,
                                         input logic [12:0] c);
        return {last, cen, inv, idx, c};
    endfunction

    function automatic exp_t mk_exp(input string nm);
        exp_t e;
        int   a;
        int   f;
        bit   cond;
        e.name  = nm;
        e.chk   = 1'b1;
        e.ctrl  = 13'h0;
        e.cf    = 1'b0;
        e.step  = 2'(m_step);
        e.fetch = (m_step == 0);
        e.err   = m_err;
        if (!reset_n) begin
            e.step  = 2'd0;
            e.fetch = 1'b1;
            e.err   = 1'b0;
        end else begin
            a = int'(opcode) * 4 + m_step;
            if (!m_valid[a]) begin
                e.chk = 1'b0;
            end else begin
                f    = (m_idx[a] < NFL) ? int'(flags[m_idx[a]]) : 0;
                cond = (f != 0) ^ m_inv[a];
                if (m_cen[a] && !cond) begin
                    e.cf   = 1'b1;
                    e.ctrl = 13'h1000;
                end else begin
                    e.ctrl = m_ctrl[a];
                end
            end
        end
        return e;
    endfunction

    task automatic model_edge(input logic en_v, input logic we_v,
                              input logic [5:0] wa, input logic [17:0] wd);
        int a;
        if (reset_n && en_v) begin
            a = int'(opcode) * 4 + m_step;
            if (m_last[a] || m_step == MAXSTEP) m_step = 0;
            else m_step = m_step + 1;
        end
        if (we_v) begin
            m_valid[wa] = 1'b1;
            m_last[wa]  = wd[17];
            m_cen[wa]   = wd[16];
            m_inv[wa]   = wd[15];
            m_idx[wa]   = int'(wd[14:13]);
            m_ctrl[wa]  = wd[12:0];
            if (reset_n && int'(wd[14:13]) >= NFL) m_err = 1'b1;
        end
    endtask

    // One clock cycle: drive, record expectation, advance model at the edge.
    task automatic cyc(input string nm, input logic en_v, input logic we_v,
                       input logic [5:0] wa, input logic [17:0] wd);
        en      = en_v;
        wr_en   = we_v;
        wr_addr = wa;
        wr_data = wd;
        q.push_back(mk_exp(nm));
        @(posedge clock);
        model_edge(en_v, we_v, wa, wd);
        #1;
    endtask

    task automatic run(input string nm, input logic en_v);
        cyc(nm, en_v, 1'b0, 6'd0, 18'd0);
    endtask

    task automatic wr(input string nm, input logic [5:0] wa, input logic [17:0] wd);
        cyc(nm, 1'b0, 1'b1, wa, wd);
    endtask

    task automatic to_fetch(input string nm);
        for (int k = 0; k < 4 && m_step != 0; k++) run(nm, 1'b1);
    endtask

    // Monitor: compare every pending expectation against the DUT.
    exp_t cur;
    bit   bad;
    always @(negedge clock) begin
        while (q.size() > 0) begin
            cur = q.pop_front();
            bad = 1'b0;
            if (step !== cur.step || fetch !== cur.fetch || wr_err !== cur.err) bad = 1'b1;
            if (cur.chk && (ctrl !== cur.ctrl || cond_fail !== cur.cf)) bad = 1'b1;
            n_cmp++;
            if (bad) begin
                n_err++;
                $display("FAIL %s: got step=%0d fetch=%b wr_err=%b ctrl=%h cond_fail=%b; want step=%0d fetch=%b wr_err=%b ctrl=%h cond_fail=%b (ctrl checked=%b)",
                         cur.name, step, fetch, wr_err, ctrl, cond_fail,
                         cur.step, cur.fetch, cur.err, cur.ctrl, cur.cf, cur.chk);
            end else begin
                $display("[%0t] %s: step=%0d ctrl=%h cond_fail=%b fetch=%b wr_err=%b ok",
                         $time, cur.name, step, ctrl, cond_fail, fetch, wr_err);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        opcode  = 4'd4;
        flags   = 3'b000;
        wr_en   = 1'b0;
        wr_addr = 6'd0;
        wr_data = 18'd0;
        m_step  = 0;
        m_err   = 1'b0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;

        @(posedge clock);
        #1;

        // Reset with arbitrary store contents; en toggled to show it is ignored.
        cyc("rst_a", 1'b1, 1'b1, 6'd16, 18'($urandom));
        cyc("rst_b", 1'b1, 1'b1, 6'd17, 18'($urandom));
        cyc("rst_c", 1'b0, 1'b1, 6'd40, 18'($urandom | 32'h6000));
        cyc("rst_d", 1'b1, 1'b1, 6'd63, 18'($urandom));

        reset_n = 1'b1;
        wr("op4_wr", 6'd16, pack(1'b1, 1'b0, 1'b0, 2'd0, 13'h0A30));
        run("op4_rd", 1'b0);
        run("op4_en", 1'b1);
        run("op4_hold", 1'b0);

        // Multi-step instruction on opcode 2.
        opcode = 4'd2;
        wr("op2_w0", 6'd8,  pack(1'b0, 1'b0, 1'b0, 2'd0, 13'h1000));
        wr("op2_w1", 6'd9,  pack(1'b0, 1'b0, 1'b0, 2'd0, 13'h0240));
        wr("op2_w2", 6'd10, pack(1'b1, 1'b0, 1'b0, 2'd0, 13'h0801));
        for (int i = 0; i < 4; i++) run("multi", 1'b1);
        for (int i = 0; i < 3; i++) run("multi_hold", 1'b0);
        to_fetch("multi_end");

        // Conditional words on opcode 0.
        opcode = 4'd0;
        wr("jc_wr", 6'd0, pack(1'b1, 1'b1, 1'b0, 2'd0, 13'h0800));
        flags = 3'b001; run("jc_c1", 1'b0);
        flags = 3'b000; run("jc_c0", 1'b0);
        flags = 3'b110; run("jc_c0_other", 1'b0);
        wr("jnz_wr", 6'd0, pack(1'b1, 1'b1, 1'b1, 2'd1, 13'h0800));
        flags = 3'b000; run("jnz_z0", 1'b0);
        flags = 3'b010; run("jnz_z1", 1'b0);
        flags = 3'b011; run("jnz_z1_en", 1'b1);
        flags = 3'b000;

        // Wrap on opcode 7: no last bit anywhere.
        opcode = 4'd7;
        for (int s = 0; s < 4; s++)
            wr("op7_wr", 6'(28 + s), pack(1'b0, 1'b0, 1'b0, 2'd0, 13'(13'h0100 + s)));
        for (int i = 0; i < 5; i++) run("wrap", 1'b1);
        to_fetch("wrap_end");

        // Same-address write/read hazard on opcode 3 step 1.
        opcode = 4'd3;
        wr("op3_w0", 6'd12, pack(1'b0, 1'b0, 1'b0, 2'd0, 13'h0111));
        wr("op3_w1", 6'd13, pack(1'b1, 1'b0, 1'b0, 2'd0, 13'h0222));
        run("op3_s0", 1'b1);
        wr("haz_old", 6'd13, pack(1'b1, 1'b0, 1'b0, 2'd0, 13'h0333));
        run("haz_new", 1'b0);
        run("haz_last", 1'b1);

        // Out-of-range cond_idx: sticky error, and the flag reads as 0.
        opcode = 4'd5;
        flags  = 3'b111;
        wr("err_wr", 6'd20, pack(1'b1, 1'b1, 1'b0, 2'd3, 13'h0444));
        run("err_set", 1'b0);
        wr("err_good_wr", 6'd21, pack(1'b0, 1'b0, 1'b0, 2'd1, 13'h0555));
        run("err_sticky", 1'b1);
        flags = 3'b000;

        // Asynchronous reset in the middle of an opcode 2 instruction.
        opcode = 4'd2;
        run("mid_s0", 1'b1);
        run("mid_s1", 1'b1);
        run("mid_s2", 1'b0);
        #1;
        reset_n = 1'b0;
        m_step  = 0;
        m_err   = 1'b0;
        q.push_back(mk_exp("async_rst"));
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        run("post_rst", 1'b0);
        opcode = 4'd4;
        run("retained_op4", 1'b0);

        // Randomised phase: fill the store, then random traffic.
        for (int i = 0; i < 64; i++) begin
            opcode = 4'($urandom);
            flags  = 3'($urandom);
            wr("rnd_prog", 6'(i), 18'($urandom));
        end
        for (int i = 0; i < 300; i++) begin
            opcode = 4'($urandom);
            flags  = 3'($urandom);
            cyc("rnd", 1'($urandom), ($urandom_range(0, 7) == 0),
                6'($urandom), 18'($urandom));
        end

        en    = 1'b0;
        wr_en = 1'b0;
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clock);
        #1;
        if (q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
